boot_loader: RTL and testbench

Post-reset boot sequencer that sits directly downstream of the 16-word boot ROM. It reads the ROM image word by word over the ROM's chip-select interface and copies each word into main RAM starting at a fixed base address. The CPU is held off the bus until the copy completes. After completion it asserts `done` and releases the CPU, which then fetches the loaded program from RAM.

---
 rtl/boot_loader.sv | 100 ++++++++++
 tb/tb_boot_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// Post-reset boot sequencer: copies the boot ROM image into RAM word by word,
// holding the CPU off the bus until the copy is complete.
module boot_loader #(
  parameter int                ADDR_W       = 12,
  parameter logic [ADDR_W-1:0] RAM_BASE     = '0,
  parameter int                ROM_WORDS    = 16,
  parameter bit                STOP_ON_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reload,
  output logic              rom_cs,
  output logic              rom_we,
  output logic [3:0]        rom_addr,
  input  logic [15:0]       rom_dout,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_din,
  input  logic              ram_ready,
  output logic              cpu_hold,
  output logic              done,
  output logic [4:0]        count
);

  typedef enum logic [1:0] {RD, WR, DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(ROM_WORDS - 1);

  state_t     state;
  logic [3:0] idx;

  assign rom_we = 1'b0;

  // ram_din doubles as the capture register for the word read in RD; it is
  // only driven onto the bus while WR holds ram_cs high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RD;
      idx      <= '0;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      ram_cs   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= RAM_BASE;
      ram_din  <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      count    <= '0;
    end else begin
      case (state)
        RD: begin
          ram_din <= rom_dout;
          rom_cs  <= 1'b0;
          if (STOP_ON_ZERO && rom_dout == 16'h0000) begin
            state    <= DONE;
            cpu_hold <= 1'b0;
            done     <= 1'b1;
          end else begin
            state    <= WR;
            ram_cs   <= 1'b1;
            ram_we   <= 1'b1;
            ram_addr <= RAM_BASE + ADDR_W'(idx);
          end
        end
        WR: begin
          // Everything stays frozen until the RAM accepts the write.
          if (ram_ready) begin
            count  <= count + 5'd1;
            ram_cs <= 1'b0;
            ram_we <= 1'b0;
            if (idx == LAST_IDX) begin
              state    <= DONE;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end else begin
              idx      <= idx + 4'd1;
              state    <= RD;
              rom_cs   <= 1'b1;
              rom_addr <= idx + 4'd1;
            end
          end
        end
        DONE: begin
          if (reload) begin
            state    <= RD;
            idx      <= '0;
            count    <= '0;
            done     <= 1'b0;
            cpu_hold <= 1'b1;
            rom_cs   <= 1'b1;
            rom_addr <= '0;
          end
        end
        default: state <= RD;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: three instances (zero-stop, full scan,
// wrapping base) share one ROM image and are checked against a write-list model.
module tb_boot_loader;

  localparam logic [11:0] WRAP_BASE = 12'hFFC;

  logic        clk;
  logic [2:0]  rst;
  logic [2:0]  reload;
  logic [2:0]  ready;
  logic        rom_cs   [3];
  logic        rom_we   [3];
  logic [3:0]  rom_addr [3];
  logic [15:0] rom_dout [3];
  logic        ram_cs   [3];
  logic        ram_we   [3];
  logic [11:0] ram_addr [3];
  logic [15:0] ram_din  [3];
  logic        cpu_hold [3];
  logic        done     [3];
  logic [4:0]  count    [3];

  logic [15:0] rom_img [16];

  int n_checks = 0;
  int n_fails  = 0;

  logic [11:0] log_addr [3][1024];
  logic [15:0] log_data [3][1024];
  int          got_n    [3] = '{0, 0, 0};

  logic [11:0] exp_addr [16];
  logic [15:0] exp_data [16];
  int          exp_n;
  bit          exp_stop;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign rom_dout[0] = rom_img[rom_addr[0]];
  assign rom_dout[1] = rom_img[rom_addr[1]];
  assign rom_dout[2] = rom_img[rom_addr[2]];

  boot_loader #(.ADDR_W(12), .RAM_BASE(12'h000), .ROM_WORDS(16), .STOP_ON_ZERO(1'b1)) u0 (
    .clk(clk), .rst(rst[0]), .reload(reload[0]),
    .rom_cs(rom_cs[0]), .rom_we(rom_we[0]), .rom_addr(rom_addr[0]), .rom_dout(rom_dout[0]),
    .ram_cs(ram_cs[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]), .ram_din(ram_din[0]),
    .ram_ready(ready[0]), .cpu_hold(cpu_hold[0]), .done(done[0]), .count(count[0]));

  boot_loader #(.ADDR_W(12), .RAM_BASE(12'h000), .ROM_WORDS(16), .STOP_ON_ZERO(1'b0)) u1 (
    .clk(clk), .rst(rst[1]), .reload(reload[1]),
    .rom_cs(rom_cs[1]), .rom_we(rom_we[1]), .rom_addr(rom_addr[1]), .rom_dout(rom_dout[1]),
    .ram_cs(ram_cs[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]), .ram_din(ram_din[1]),
    .ram_ready(ready[1]), .cpu_hold(cpu_hold[1]), .done(done[1]), .count(count[1]));

  boot_loader #(.ADDR_W(12), .RAM_BASE(WRAP_BASE), .ROM_WORDS(16), .STOP_ON_ZERO(1'b1)) u2 (
    .clk(clk), .rst(rst[2]), .reload(reload[2]),
    .rom_cs(rom_cs[2]), .rom_we(rom_we[2]), .rom_addr(rom_addr[2]), .rom_dout(rom_dout[2]),
    .ram_cs(ram_cs[2]), .ram_we(ram_we[2]), .ram_addr(ram_addr[2]), .ram_din(ram_din[2]),
    .ram_ready(ready[2]), .cpu_hold(cpu_hold[2]), .done(done[2]), .count(count[2]));

  // RAM side: log every accepted write per instance.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (ram_cs[g] && ram_we[g] && ready[g] && got_n[g] < 1024) begin
        log_addr[g][got_n[g]] <= ram_addr[g];
        log_data[g][got_n[g]] <= ram_din[g];
        got_n[g]              <= got_n[g] + 1;
      end
    end
  end

  function automatic bit stop_of(input int inst);
    return inst != 1;
  endfunction

  function automatic logic [11:0] base_of(input int inst);
    return (inst == 2) ? WRAP_BASE : 12'h000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, expv, $time);
    end
  endtask

  // Expected write list: ROM words in order, cut at the first zero if stopping.
  task automatic buildModel(input int inst);
    exp_n    = 0;
    exp_stop = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (stop_of(inst) && rom_img[i] == 16'h0000) begin
        exp_stop = 1'b1;
        break;
      end
      exp_addr[exp_n] = base_of(inst) + 12'(i);
      exp_data[exp_n] = rom_img[i];
      exp_n++;
    end
  endtask

  task automatic loadDefaultImage();
    logic [15:0] img [8] = '{16'hF200, 16'h4000, 16'hF800, 16'h1007,
                             16'hF400, 16'h3010, 16'h4000, 16'h0007};
    for (int i = 0; i < 16; i++) rom_img[i] = (i < 8) ? img[i] : 16'h0000;
  endtask

  task automatic checkReset(input int inst);
    checkOutput("rst_rom_cs",   rom_cs[inst],   0);
    checkOutput("rst_rom_we",   rom_we[inst],   0);
    checkOutput("rst_rom_addr", rom_addr[inst], 0);
    checkOutput("rst_ram_cs",   ram_cs[inst],   0);
    checkOutput("rst_ram_we",   ram_we[inst],   0);
    checkOutput("rst_ram_addr", ram_addr[inst], base_of(inst));
    checkOutput("rst_ram_din",  ram_din[inst],  0);
    checkOutput("rst_cpu_hold", cpu_hold[inst], 1);
    checkOutput("rst_done",     done[inst],     0);
    checkOutput("rst_count",    count[inst],    0);
  endtask

  // waits < 0 skips the completion-cycle check (random ram_ready runs).
  task automatic checkLoad(input int inst, input int start, input int done_cycle, input int waits);
    buildModel(inst);
    if (waits >= 0)
      checkOutput("done_cycle", done_cycle, 2 * exp_n + 1 + (exp_stop ? 1 : 0) + waits);
    checkOutput("done",     done[inst],     1);
    checkOutput("cpu_hold", cpu_hold[inst], 0);
    checkOutput("count",    count[inst],    exp_n);
    checkOutput("n_writes", got_n[inst] - start, exp_n);
    for (int i = 0; i < exp_n && start + i < got_n[inst]; i++) begin
      checkOutput("wr_addr", log_addr[inst][start + i], exp_addr[i]);
      checkOutput("wr_data", log_data[inst][start + i], exp_data[i]);
    end
  endtask

  // Runs one load from reset. Cycle numbering: cycle 1 ends at the first edge
  // after reset release, so after edge c the design is in cycle c+1.
  task automatic applyStimulus(input int inst, input int low_from, input int low_to,
                               input logic [11:0] hold_addr, input logic [15:0] hold_data,
                               input bit rand_ready, input int reload_at, input int reset_at,
                               output int done_cycle, output int start);
    int c;
    int guard;
    int cur;
    bit armed;
    armed = (reset_at > 0);
    rst[inst] = 1'b1;
    @(negedge clk);
    ready[inst]  = 1'b1;
    reload[inst] = 1'b0;
    start = got_n[inst];
    @(negedge clk);
    rst[inst] = 1'b0;
    c = 0;
    guard = 0;
    while (!done[inst] && guard < 400) begin
      @(posedge clk);
      #1;
      c++;
      guard++;
      cur = c + 1;
      ready[inst]  = rand_ready ? ($urandom_range(0, 3) != 0)
                                : !(cur >= low_from && cur <= low_to);
      reload[inst] = (cur == reload_at);
      if (low_from > 0 && cur >= low_from && cur <= low_to + 1) begin
        checkOutput("hold_ram_cs",   ram_cs[inst],   1);
        checkOutput("hold_ram_we",   ram_we[inst],   1);
        checkOutput("hold_ram_addr", ram_addr[inst], hold_addr);
        checkOutput("hold_ram_din",  ram_din[inst],  hold_data);
      end
      if (armed && cur == reset_at) begin
        armed = 1'b0;
        #1 rst[inst] = 1'b1;
        #1 checkReset(inst);
        start = got_n[inst];
        #1 rst[inst] = 1'b0;
        c = 0;
      end
    end
    if (!done[inst]) checkOutput("done_timeout", 0, 1);
    done_cycle   = c + 1;
    ready[inst]  = 1'b1;
    reload[inst] = 1'b0;
  endtask

  initial begin
    int dc;
    int st;
    int c;
    int inst;
    rst    = 3'b111;
    reload = 3'b000;
    ready  = 3'b111;
    loadDefaultImage();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) checkReset(i);

    $display("[TB] default image, zero-stop");
    applyStimulus(0, 0, -1, 12'h0, 16'h0, 1'b0, 0, 0, dc, st);
    checkLoad(0, st, dc, 0);

    $display("[TB] default image, full scan");
    applyStimulus(1, 0, -1, 12'h0, 16'h0, 1'b0, 0, 0, dc, st);
    checkLoad(1, st, dc, 0);

    $display("[TB] wait states on word 2");
    applyStimulus(0, 6, 8, 12'h002, 16'hF800, 1'b0, 0, 0, dc, st);
    checkLoad(0, st, dc, 3);

    $display("[TB] reset during write of word 4");
    applyStimulus(0, 0, -1, 12'h0, 16'h0, 1'b0, 0, 10, dc, st);
    checkLoad(0, st, dc, 0);

    $display("[TB] reload ignored in RD and WR");
    applyStimulus(0, 0, -1, 12'h0, 16'h0, 1'b0, 3, 0, dc, st);
    checkLoad(0, st, dc, 0);
    applyStimulus(0, 0, -1, 12'h0, 16'h0, 1'b0, 4, 0, dc, st);
    checkLoad(0, st, dc, 0);

    $display("[TB] reload from DONE");
    st = got_n[0];
    @(negedge clk);
    reload[0] = 1'b1;
    @(posedge clk);
    #1;
    reload[0] = 1'b0;
    checkOutput("reload_done",     done[0],     0);
    checkOutput("reload_cpu_hold", cpu_hold[0], 1);
    checkOutput("reload_count",    count[0],    0);
    checkOutput("reload_rom_cs",   rom_cs[0],   1);
    checkOutput("reload_rom_addr", rom_addr[0], 0);
    c = 0;
    while (!done[0] && c < 400) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (!done[0]) checkOutput("done_timeout", 0, 1);
    checkLoad(0, st, c + 1, 0);

    $display("[TB] wrapping base address");
    applyStimulus(2, 0, -1, 12'h0, 16'h0, 1'b0, 0, 0, dc, st);
    checkLoad(2, st, dc, 0);

    $display("[TB] random images with random ram_ready");
    for (int r = 0; r < 9; r++) begin
      inst = r % 3;
      for (int i = 0; i < 16; i++)
        rom_img[i] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      applyStimulus(inst, 0, -1, 12'h0, 16'h0, 1'b1, 0, 0, dc, st);
      checkLoad(inst, st, dc, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
